uart_pixel_receiver: RTL and testbench

Receive end of the pixel serial link. Deserialises 8N1 UART frames from `serialIn`, oversampled 16× on the UART clock, and reassembles byte pairs into 16-bit pixel words. The first byte of a pair is the MSB and the second is the LSB. Each completed word is written into a downstream FIFO write port. The block reports framing, overrun and pair-timeout errors.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_pixel_receiver_if.sv | 13 +
 rtl/uart_rx_byte.sv | 101 ++++++++++
 rtl/uart_pixel_receiver.sv | 91 +++++++++
 tb/tb_uart_pixel_receiver.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and sample-point constants for the pixel-link UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  // Mid-bit and last-sample indices for an oversample ratio of 2**log2.
  function automatic int mid_sample(input int log2);
    return (1 << (log2 - 1)) - 1;
  endfunction

  function automatic int last_sample(input int log2);
    return (1 << log2) - 1;
  endfunction

  localparam int DFLT_SAMPLE_LOG2 = 4;
  localparam int MID_SAMPLE       = mid_sample(DFLT_SAMPLE_LOG2);
  localparam int LAST_SAMPLE      = last_sample(DFLT_SAMPLE_LOG2);

endpackage

// File: rtl/uart_pixel_receiver_if.sv
// Downstream FIFO write port carrying assembled pixel words.
interface uart_pixel_receiver_if #(
  parameter int PIX_W = 16
);
  // push is a one-cycle write strobe qualified by full sampled on the same edge
  // that decides the push; a word offered while full is dropped, never retried.
  logic [PIX_W-1:0] pixelData;
  logic             push;
  logic             full;

  modport master (output pixelData, output push, input full);
  modport slave  (input pixelData, input push, output full);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: two-flop synchroniser, oversampled bit FSM, shift register.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int SAMPLE_LOG2 = 4,
  parameter int WORD_SIZE   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serialIn,
  output logic [WORD_SIZE-1:0] rxByte,
  output logic                 byteValid,
  output logic                 frameErr,
  output logic                 byte_done,
  output logic                 frame_bad,
  output logic [WORD_SIZE-1:0] shift_q,
  output rx_state_e            state
);

  localparam logic [SAMPLE_LOG2-1:0] S_MID  = SAMPLE_LOG2'(mid_sample(SAMPLE_LOG2));
  localparam logic [SAMPLE_LOG2-1:0] S_LAST = SAMPLE_LOG2'(last_sample(SAMPLE_LOG2));
  localparam int                     BW     = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [BW-1:0]          B_LAST = BW'(WORD_SIZE - 1);

  logic                   sync1;
  logic                   sync2;
  logic [SAMPLE_LOG2-1:0] s_cnt;
  logic [BW-1:0]          b_cnt;
  logic                   stop_tick;

  // Stop-sample events are exported unregistered so the pair assembler can
  // register its push in the same edge that registers byteValid.
  assign stop_tick = (state == STOP) && (s_cnt == S_LAST);
  assign byte_done = stop_tick && sync2;
  assign frame_bad = stop_tick && !sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= serialIn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s_cnt     <= '0;
      b_cnt     <= '0;
      shift_q   <= '0;
      rxByte    <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      byteValid <= byte_done;
      frameErr  <= frame_bad;
      if (byte_done) rxByte <= shift_q;
      case (state)
        IDLE: begin
          s_cnt <= '0;
          if (!sync2) state <= START;
        end
        START: begin
          if (s_cnt == S_MID) begin
            s_cnt <= '0;
            b_cnt <= '0;
            state <= sync2 ? IDLE : DATA;
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        DATA: begin
          if (s_cnt == S_LAST) begin
            s_cnt   <= '0;
            shift_q <= {sync2, shift_q[WORD_SIZE-1:1]};
            if (b_cnt == B_LAST) begin
              b_cnt <= '0;
              state <= STOP;
            end else begin
              b_cnt <= b_cnt + 1'b1;
            end
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        STOP: begin
          if (s_cnt == S_LAST) begin
            s_cnt <= '0;
            state <= IDLE;
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_pixel_receiver.sv
// Pixel-link receive end: pairs UART bytes (MSB first) into 16-bit FIFO words.
module uart_pixel_receiver
  import uart_pkg::*;
#(
  parameter int SAMPLE_LOG2  = 4,
  parameter int WORD_SIZE    = 8,
  parameter int PAIR_TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   serialIn,
  uart_pixel_receiver_if.master  fifo,
  output logic [WORD_SIZE-1:0]   rxByte,
  output logic                   byteValid,
  output logic                   frameErr,
  output logic                   overrun,
  output logic                   pairTimeout,
  output rx_state_e              dbg_state,
  output logic                   dbg_have_msb
);

  localparam int            TW     = (PAIR_TIMEOUT > 2) ? $clog2(PAIR_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(PAIR_TIMEOUT - 1);

  logic                 byte_done;
  logic                 frame_bad;
  logic [WORD_SIZE-1:0] shift_q;
  logic                 have_msb;
  logic [WORD_SIZE-1:0] msb_q;
  logic [TW-1:0]        t_cnt;

  uart_rx_byte #(
    .SAMPLE_LOG2 (SAMPLE_LOG2),
    .WORD_SIZE   (WORD_SIZE)
  ) u_rx_byte (
    .clk       (clk),
    .reset     (reset),
    .serialIn  (serialIn),
    .rxByte    (rxByte),
    .byteValid (byteValid),
    .frameErr  (frameErr),
    .byte_done (byte_done),
    .frame_bad (frame_bad),
    .shift_q   (shift_q),
    .state     (dbg_state)
  );

  assign dbg_have_msb = have_msb;

  // A completed byte takes priority over timeout expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      have_msb       <= 1'b0;
      msb_q          <= '0;
      t_cnt          <= '0;
      fifo.pixelData <= '0;
      fifo.push      <= 1'b0;
      overrun        <= 1'b0;
      pairTimeout    <= 1'b0;
    end else begin
      fifo.push   <= 1'b0;
      overrun     <= 1'b0;
      pairTimeout <= 1'b0;
      if (byte_done) begin
        if (!have_msb) begin
          msb_q    <= shift_q;
          have_msb <= 1'b1;
          t_cnt    <= '0;
        end else begin
          have_msb <= 1'b0;
          if (!fifo.full) begin
            fifo.pixelData <= {msb_q, shift_q};
            fifo.push      <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
      end else if (frame_bad) begin
        have_msb <= 1'b0;
      end else if (have_msb) begin
        if (t_cnt == T_LAST) begin
          pairTimeout <= 1'b1;
          have_msb    <= 1'b0;
        end else begin
          t_cnt <= t_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_pixel_receiver.sv
// Scoreboard bench for uart_pixel_receiver: directed frames, event queue, monitor.
module tb_uart_pixel_receiver;
  import uart_pkg::*;

  localparam int PAIR_TIMEOUT = 4096;
  localparam int W            = 20;
  localparam logic [3:0] K_BV   = 4'd1;
  localparam logic [3:0] K_PUSH = 4'd2;
  localparam logic [3:0] K_FERR = 4'd3;
  localparam logic [3:0] K_OVR  = 4'd4;
  localparam logic [3:0] K_PTO  = 4'd5;

  // clock / reset
  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic serialIn = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rxByte;
  logic       byteValid;
  logic       frameErr;
  logic       overrun;
  logic       pairTimeout;
  rx_state_e  dbg_state;
  logic       dbg_have_msb;

  uart_pixel_receiver_if fifo_if ();

  uart_pixel_receiver #(
    .SAMPLE_LOG2  (4),
    .WORD_SIZE    (8),
    .PAIR_TIMEOUT (PAIR_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serialIn     (serialIn),
    .fifo         (fifo_if),
    .rxByte       (rxByte),
    .byteValid    (byteValid),
    .frameErr     (frameErr),
    .overrun      (overrun),
    .pairTimeout  (pairTimeout),
    .dbg_state    (dbg_state),
    .dbg_have_msb (dbg_have_msb)
  );

  int cyc       = 0;
  int start_cyc = 0;
  bit lat_armed = 1'b0;
  bit done      = 1'b0;
  int checks    = 0;
  int errors    = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  task automatic expect_ev(input logic [3:0] k, input logic [15:0] d);
    exp_q.push_back({k, d});
  endtask

  task automatic check_ev(input logic [3:0] k, input logic [15:0] d, input string name);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event %h with empty expected queue", name, {k, d});
    end else begin
      exp = exp_q.pop_front();
      if (exp !== {k, d}) begin
        errors++;
        $display("FAIL %s: got event %h expected %h", name, {k, d}, exp);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (byteValid) begin
      check_ev(K_BV, {8'h00, rxByte}, "byte_valid");
      if (lat_armed) begin
        lat_armed = 1'b0;
        chk("latency_edge", 32'(cyc - start_cyc - 1), 32'd154);
      end
    end
    if (fifo_if.push) begin
      check_ev(K_PUSH, fifo_if.pixelData, "push");
      chk("push_with_bv", 32'(byteValid), 32'd1);
    end
    if (overrun) begin
      check_ev(K_OVR, 16'h0000, "overrun");
      chk("overrun_with_bv", 32'(byteValid), 32'd1);
    end
    if (frameErr)    check_ev(K_FERR, 16'h0000, "frame_err");
    if (pairTimeout) check_ev(K_PTO, 16'h0000, "pair_timeout");
  end

  // driver: call aligned to a negedge; idle_after == 0 chains frames back to back
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int idle_after);
    serialIn  = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      serialIn = b[i];
    end
    repeat (16) @(negedge clk);
    serialIn = stop_bit;
    repeat (16) @(negedge clk);
    if (idle_after > 0) begin
      serialIn = 1'b1;
      repeat (idle_after) @(negedge clk);
    end
  endtask

  task automatic send_pair(input logic [7:0] m, input logic [7:0] l);
    expect_ev(K_BV, {8'h00, m});
    expect_ev(K_BV, {8'h00, l});
    expect_ev(K_PUSH, {m, l});
    send_frame(m, 1'b1, 4);
    send_frame(l, 1'b1, 4);
  endtask

  initial begin
    fifo_if.full = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pixel", 32'(fifo_if.pixelData), 32'h0);
    chk("rst_rxbyte", 32'(rxByte), 32'h0);
    chk("rst_strobes", 32'({fifo_if.push, byteValid, frameErr, overrun, pairTimeout}), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_have_msb", 32'(dbg_have_msb), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // basic pair, back to back, with latency check on the first byte
    expect_ev(K_BV, 16'h0012);
    expect_ev(K_BV, 16'h0034);
    expect_ev(K_PUSH, 16'h1234);
    lat_armed = 1'b1;
    send_frame(8'h12, 1'b1, 0);
    send_frame(8'h34, 1'b1, 8);
    chk("pixel_1234", 32'(fifo_if.pixelData), 32'h1234);

    // short low glitch on idle line
    serialIn = 1'b0;
    repeat (5) @(negedge clk);
    serialIn = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_idle", 32'(dbg_state), 32'(IDLE));
    send_pair(8'hAB, 8'hCD);

    // bad stop bit with no MSB pending
    expect_ev(K_FERR, 16'h0000);
    send_frame(8'h55, 1'b0, 32);
    send_pair(8'hFF, 8'hAA);

    // bad stop bit while an MSB is pending resynchronises the pair
    expect_ev(K_BV, 16'h0011);
    send_frame(8'h11, 1'b1, 4);
    chk("have_msb_set", 32'(dbg_have_msb), 32'h1);
    expect_ev(K_FERR, 16'h0000);
    send_frame(8'h66, 1'b0, 32);
    chk("resync_have_msb", 32'(dbg_have_msb), 32'h0);
    send_pair(8'h5C, 8'h3E);

    // downstream full drops the word
    fifo_if.full = 1'b1;
    expect_ev(K_BV, 16'h0001);
    expect_ev(K_BV, 16'h0002);
    expect_ev(K_OVR, 16'h0000);
    send_frame(8'h01, 1'b1, 4);
    send_frame(8'h02, 1'b1, 4);
    fifo_if.full = 1'b0;
    chk("pixel_held_on_overrun", 32'(fifo_if.pixelData), 32'h5C3E);
    send_pair(8'h03, 8'h04);

    // lone MSB times out
    expect_ev(K_BV, 16'h0077);
    expect_ev(K_PTO, 16'h0000);
    send_frame(8'h77, 1'b1, 4);
    chk("timeout_pending", 32'(dbg_have_msb), 32'h1);
    repeat (PAIR_TIMEOUT + 20) @(negedge clk);
    chk("timeout_cleared", 32'(dbg_have_msb), 32'h0);
    send_pair(8'h88, 8'h99);

    // reset in the middle of an LSB frame
    expect_ev(K_BV, 16'h005A);
    send_frame(8'h5A, 1'b1, 4);
    serialIn = 1'b0;
    repeat (16) @(negedge clk);
    serialIn = 1'b1;
    repeat (16) @(negedge clk);
    serialIn = 1'b0;
    repeat (16) @(negedge clk);
    serialIn = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_data_state", 32'(dbg_state), 32'(DATA));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_pixel", 32'(fifo_if.pixelData), 32'h0);
    chk("mid_rst_rxbyte", 32'(rxByte), 32'h0);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("mid_rst_have_msb", 32'(dbg_have_msb), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    send_pair(8'h10, 8'h20);
    repeat (40) @(negedge clk);
    chk("pixel_hold", 32'(fifo_if.pixelData), 32'h1020);

    // drain, bounded
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_event: got nothing expected %h", exp_q.pop_front());
    end

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    if (!done) begin
      $display("FAIL watchdog: got no completion expected finish within 60000 cycles");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
